sa_skew_feeder: RTL and testbench
=================================

// Module: sa_skew_feeder
// PURPOSE
// - Upstream operand stage of the systolic array (SA): accepts one column of A (SA_R elems) and one
//   row of B (SA_C elems) per beat for K_LEN beats and drives SA row/column inputs diagonally skewed.
// - Row lane i is delayed i cycles and col lane j is delayed j cycles; idle lanes carry zero.
// - Also generates the SA start pulse and signals completion after the array has drained.
// PARAMETERS
// - D_W     8   operand width (signed fixed point, same format as SA)
// - SA_R    16  SA rows = number of A lanes / O_X outputs
// - SA_C    16  SA columns = number of B lanes / O_W outputs
// - K_LEN   16  inner dimension = valid beats accepted per job
// - PE_LAT  1   PE x/w forwarding latency in cycles, used for the drain count
// PORTS
// - I_CLK          in   1            clock, all logic on rising edge
// - I_ASYN_RST     in   1            asynchronous active-high reset
// - I_START        in   1            job start pulse, honoured only in S_IDLE
// - I_VLD          in   1            I_A/I_B beat valid
// - O_RDY          out  1            beat ready (high only in S_FEED)
// - I_A            in   D_W x SA_R   column k of A
// - I_B            in   D_W x SA_C   row k of B
// - O_SA_START     out  1            1-cycle start pulse to SA
// - O_X            out  D_W x SA_R   skewed row operands to SA
// - O_W            out  D_W x SA_C   skewed column operands to SA
// - O_BUSY         out  1            high in S_FEED/S_FLUSH
// - O_DONE         out  1            1-cycle pulse, all products issued and drained
// BEHAVIOUR
// - Reset (async, anytime incl. mid-job): state S_IDLE; every delay-line reg, O_X, O_W = 0;
//   O_RDY=O_SA_START=O_BUSY=O_DONE=0; counters 0. Job in progress is abandoned; no O_DONE.
// - FSM: S_IDLE -(I_START)-> S_FEED -(K_LEN-th beat accepted)-> S_FLUSH -(flush cnt = FLUSH_CYC-1)->
//   S_DONE -> S_IDLE (unconditional, one cycle). O_DONE=1 exactly while in S_DONE.
// - O_SA_START registered: high the cycle after I_START is taken in S_IDLE (coincides with first
//   S_FEED cycle). I_START in any other state ignored.
// - Handshake: beat accepted when I_VLD & O_RDY. O_RDY = (state==S_FEED), registered from next state.
//   I_VLD in S_IDLE/S_FLUSH/S_DONE ignored, data dropped.
// - Injection value per cycle: accepted beat -> I_A/I_B; otherwise (bubble in S_FEED, or S_FLUSH) ->
//   all-zero vector. Bubbles are legal: zero x zero adds nothing and skew alignment is preserved.
// - Skew: lane i of A passes through i+1 regs: value injected at cycle c appears on O_X[i] at c+1+i;
//   likewise O_W[j] at c+1+j. O_X[0]/O_W[0] latency = 1 cycle.
// - Beat counter: $clog2(K_LEN+1) bits, counts accepted beats, clears on S_IDLE. No wrap:
//   it cannot exceed K_LEN because O_RDY drops on the K_LEN-th accept.
// - FLUSH_CYC = SA_R + SA_C - 1 + PE_LAT*(SA_R+SA_C-2) zero-injection cycles, sized so the last
//   operand has reached PE(SA_R-1,SA_C-1) and been accumulated before O_DONE.
// - No arithmetic on data; values pass unchanged (no sign extension, no saturation).
// - K_LEN=1: S_FEED lasts until the single beat is accepted, then S_FLUSH immediately.
// CONFIGURATION
// - Macro SA_FEED_BUBBLE_CNT_EN.
//   Defined: extra output O_BUBBLE_CNT [15:0] = number of S_FEED cycles with no accepted beat in
//   the current/last job; clears on I_START acceptance and reset, saturates at 16'hFFFF,
//   holds after O_DONE until next start.
//   Undefined: port and counter absent; all other behaviour identical.
// TESTING (SA_R=SA_C=4, K_LEN=4, PE_LAT=1, D_W=8)
// - Reset check: assert I_ASYN_RST mid-S_FEED -> same-cycle O_X/O_W=0, O_RDY=0, state S_IDLE,
//   no O_DONE.
// - Back-to-back beats A[k]=B[k]={k+1,k+1,k+1,k+1}, I_VLD=1 -> O_X[2] shows 1,2,3,4 on cycles
//   3..6 after first accept; O_X[0] on cycles 1..4; zeros otherwise.
// - Bubble: I_VLD low for 2 cycles between beat 2 and beat 3 -> O_X[0] seq 1,2,0,0,3,4; O_RDY stays high;
//   with macro O_BUBBLE_CNT=2.
// - Completion: after 4th accept, S_FLUSH for FLUSH_CYC=13 cycles, then O_DONE for exactly 1 cycle,
//   O_BUSY falls with it.
// - I_START while busy and I_VLD in S_IDLE -> ignored: no second O_SA_START, beat count unchanged.
// - Signed data: A lane=8'h80, B lane=8'h7F -> appear unchanged on O_X/O_W with correct skew.

Source files
------------

// File: rtl/sa_skew_feeder.sv
// Operand skew feeder for the systolic array: diagonal delay lines, start pulse and drain-aware done.
// Optional macro SA_FEED_BUBBLE_CNT_EN adds O_BUBBLE_CNT (S_FEED cycles without an accepted beat).
module sa_skew_feeder #(
    parameter int D_W    = 8,
    parameter int SA_R   = 16,
    parameter int SA_C   = 16,
    parameter int K_LEN  = 16,
    parameter int PE_LAT = 1
) (
    input  logic                       I_CLK,
    input  logic                       I_ASYN_RST,
    input  logic                       I_START,
    input  logic                       I_VLD,
    output logic                       O_RDY,
    input  logic [SA_R-1:0][D_W-1:0]   I_A,
    input  logic [SA_C-1:0][D_W-1:0]   I_B,
    output logic                       O_SA_START,
    output logic [SA_R-1:0][D_W-1:0]   O_X,
    output logic [SA_C-1:0][D_W-1:0]   O_W,
    output logic                       O_BUSY,
    output logic                       O_DONE
`ifdef SA_FEED_BUBBLE_CNT_EN
    ,
    output logic [15:0]                O_BUBBLE_CNT
`endif
);

    // Drain time: last operand must cross the full diagonal of the array before done.
    localparam int FLUSH_CYC = SA_R + SA_C - 1 + PE_LAT * (SA_R + SA_C - 2);
    localparam int BCW = $clog2(K_LEN + 1);
    localparam int FCW = $clog2(FLUSH_CYC + 1);
    localparam logic [BCW-1:0] LAST_BEAT  = BCW'(K_LEN - 1);
    localparam logic [FCW-1:0] LAST_FLUSH = FCW'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [BCW-1:0] beat_q;
    logic [FCW-1:0] flush_q;
    logic           rdy_q, sa_start_q, busy_q, done_q;
    logic           accept;

    logic signed [D_W-1:0] inj_a [SA_R];
    logic signed [D_W-1:0] inj_b [SA_C];

    assign accept = I_VLD & rdy_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (I_START) state_d = S_FEED;
            S_FEED:  if (accept && beat_q == LAST_BEAT) state_d = S_FLUSH;
            S_FLUSH: if (flush_q == LAST_FLUSH) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            flush_q    <= '0;
            rdy_q      <= 1'b0;
            sa_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= (state_d == S_FEED);
            busy_q     <= (state_d == S_FEED) || (state_d == S_FLUSH);
            done_q     <= (state_d == S_DONE);
            sa_start_q <= (state_q == S_IDLE) && I_START;
            if (state_q == S_IDLE)
                beat_q <= '0;
            else if (accept)
                beat_q <= beat_q + 1'b1;
            if (state_q == S_FLUSH)
                flush_q <= flush_q + 1'b1;
            else
                flush_q <= '0;
        end
    end

`ifdef SA_FEED_BUBBLE_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] bub_q;

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST)
            bub_q <= '0;
        else if (state_q == S_IDLE && I_START)
            bub_q <= '0;
        else if (state_q == S_FEED && !accept)
            bub_q <= sat_inc(bub_q);
    end

    assign O_BUBBLE_CNT = bub_q;
`endif

    // Bubbles and flush cycles inject zeros so the diagonal alignment is never broken.
    always_comb begin
        for (int i = 0; i < SA_R; i++) inj_a[i] = accept ? I_A[i] : '0;
        for (int j = 0; j < SA_C; j++) inj_b[j] = accept ? I_B[j] : '0;
    end

    for (genvar i = 0; i < SA_R; i++) begin : g_row
        logic signed [D_W-1:0] sr_q [i+1];
        always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
            if (I_ASYN_RST) begin
                for (int s = 0; s <= i; s++) sr_q[s] <= '0;
            end else begin
                sr_q[0] <= inj_a[i];
                for (int s = 1; s <= i; s++) sr_q[s] <= sr_q[s-1];
            end
        end
        assign O_X[i] = sr_q[i];
    end

    for (genvar j = 0; j < SA_C; j++) begin : g_col
        logic signed [D_W-1:0] sr_q [j+1];
        always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
            if (I_ASYN_RST) begin
                for (int s = 0; s <= j; s++) sr_q[s] <= '0;
            end else begin
                sr_q[0] <= inj_b[j];
                for (int s = 1; s <= j; s++) sr_q[s] <= sr_q[s-1];
            end
        end
        assign O_W[j] = sr_q[j];
    end

    assign O_RDY      = rdy_q;
    assign O_SA_START = sa_start_q;
    assign O_BUSY     = busy_q;
    assign O_DONE     = done_q;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder: per-lane scoreboard for skewed operands plus control sequence checks.
module tb_sa_skew_feeder;
    localparam int D_W = 8, SA_R = 4, SA_C = 4, K_LEN = 4, PE_LAT = 1;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, vld = 1'b0;
    logic rdy, sas, busy, done;
    logic [SA_R-1:0][D_W-1:0] a = '0;
    logic [SA_C-1:0][D_W-1:0] b = '0;
    logic [SA_R-1:0][D_W-1:0] ox;
    logic [SA_C-1:0][D_W-1:0] ow;
`ifdef SA_FEED_BUBBLE_CNT_EN
    logic [15:0] bcnt;
`endif

    int errors = 0, checks = 0;
    bit mon_en = 1'b0;
    logic [D_W-1:0] qx [SA_R][$];
    logic [D_W-1:0] qw [SA_C][$];

    typedef struct {
        bit st; bit v; logic [7:0] d;
        bit e_rdy; bit e_busy; bit e_sas; logic [7:0] e_x0;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    sa_skew_feeder #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_LEN(K_LEN), .PE_LAT(PE_LAT)) dut (
        .I_CLK(clk), .I_ASYN_RST(rst), .I_START(start), .I_VLD(vld), .O_RDY(rdy),
        .I_A(a), .I_B(b), .O_SA_START(sas), .O_X(ox), .O_W(ow), .O_BUSY(busy), .O_DONE(done)
`ifdef SA_FEED_BUBBLE_CNT_EN
        , .O_BUBBLE_CNT(bcnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Lane i sees each injected value i edges later; pre-load i zeros to model that.
    task automatic sb_init();
        for (int i = 0; i < SA_R; i++) begin
            qx[i].delete();
            for (int n = 0; n < i; n++) qx[i].push_back(8'h00);
        end
        for (int j = 0; j < SA_C; j++) begin
            qw[j].delete();
            for (int n = 0; n < j; n++) qw[j].push_back(8'h00);
        end
    endtask

    always @(posedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < SA_R; i++) qx[i].push_back((vld && rdy) ? a[i] : 8'h00);
            for (int j = 0; j < SA_C; j++) qw[j].push_back((vld && rdy) ? b[j] : 8'h00);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < SA_R; i++) begin
                if (qx[i].size() == 0) chk("sb_x_empty", 0, 1);
                else chk($sformatf("sb_x%0d", i), ox[i], qx[i].pop_front());
            end
            for (int j = 0; j < SA_C; j++) begin
                if (qw[j].size() == 0) chk("sb_w_empty", 0, 1);
                else chk($sformatf("sb_w%0d", j), ow[j], qw[j].pop_front());
            end
        end
    end

    // Entered right after the last beat is accepted; junk start/valid must be ignored.
    task automatic finish_job();
        int n;
        n = 1;
        start = 1'b1; vld = 1'b1;
        a = {SA_R{8'hEE}}; b = {SA_C{8'hEE}};
        while (n < 100) begin
            step();
            if (done) break;
            n++;
            chk("flush_busy", busy, 1);
            chk("flush_rdy", rdy, 0);
            chk("flush_sas", sas, 0);
        end
        chk("flush_len", n, 13);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        start = 1'b0; vld = 1'b0;
        step();
        chk("done_1cyc", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_sas", sas, 0);
        chk("idle_rdy", rdy, 0);
    endtask

    task automatic run_job(input logic [7:0] av, input logic [7:0] bv, input bit incr);
        start = 1'b1; vld = 1'b0;
        step();
        chk("job_sas", sas, 1);
        chk("job_rdy", rdy, 1);
        chk("job_busy", busy, 1);
        start = 1'b0;
        for (int k = 0; k < K_LEN; k++) begin
            vld = 1'b1;
            for (int i = 0; i < SA_R; i++) a[i] = incr ? av + 8'(k + 16 * i) : av;
            for (int j = 0; j < SA_C; j++) b[j] = incr ? bv + 8'(k + 16 * j) : bv;
            step();
            chk($sformatf("job_rdy_k%0d", k), rdy, (k == K_LEN - 1) ? 0 : 1);
            chk("job_sas_once", sas, 0);
        end
        finish_job();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd0};
        tbl[1] = '{1'b0, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[2] = '{1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd2};
        tbl[3] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[4] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[5] = '{1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 8'd3};
        tbl[6] = '{1'b1, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 8'd4};

        repeat (2) @(negedge clk);
        chk("rst_rdy", rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sas", sas, 0);
        chk("rst_ox", ox, 0);
        chk("rst_ow", ow, 0);
        rst = 1'b0;
        #1 sb_init();
        mon_en = 1'b1;

        // Bubble job: two idle cycles between beats 2 and 3, start re-asserted while busy.
        for (int r = 0; r < 7; r++) begin
            start = tbl[r].st; vld = tbl[r].v;
            a = {SA_R{tbl[r].d}}; b = {SA_C{tbl[r].d}};
            step();
            chk($sformatf("tbl%0d_rdy", r), rdy, tbl[r].e_rdy);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
            chk($sformatf("tbl%0d_sas", r), sas, tbl[r].e_sas);
            chk($sformatf("tbl%0d_done", r), done, 0);
            chk($sformatf("tbl%0d_x0", r), ox[0], tbl[r].e_x0);
        end
        finish_job();
`ifdef SA_FEED_BUBBLE_CNT_EN
        chk("bubble_cnt", bcnt, 2);
`endif

        // Valid while idle must not be taken.
        vld = 1'b1; a = {SA_R{8'h55}}; b = {SA_C{8'h55}};
        repeat (3) begin
            step();
            chk("idle_vld_rdy", rdy, 0);
            chk("idle_vld_busy", busy, 0);
        end
`ifdef SA_FEED_BUBBLE_CNT_EN
        chk("bubble_hold", bcnt, 2);
`endif
        run_job(8'd1, 8'd1, 1'b1);
`ifdef SA_FEED_BUBBLE_CNT_EN
        chk("bubble_b2b", bcnt, 0);
`endif

        // Asynchronous reset in the middle of a feed.
        start = 1'b1; vld = 1'b0;
        step();
        start = 1'b0; vld = 1'b1; a = {SA_R{8'h09}}; b = {SA_C{8'h0A}};
        step();
        step();
        #2;
        mon_en = 1'b0;
        rst = 1'b1; vld = 1'b0;
        #1;
        chk("mid_rst_ox", ox, 0);
        chk("mid_rst_ow", ow, 0);
        chk("mid_rst_rdy", rdy, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 sb_init();
        mon_en = 1'b1;
        repeat (20) begin
            step();
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end

        run_job(8'h80, 8'h7F, 1'b0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
